// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_pkg
// Purpose  : Shared definitions for the decode (ID) stage: destination-select
//            encodings, scoreboard depth limit and the bubble control word.
// Revision : 1.0  initial release
// ============================================================================
package id_pkg;

  // Destination register selection carried on Ctrl_DestSel
  typedef enum logic [1:0] {
    DEST_RT   = 2'd0,
    DEST_RD   = 2'd1,
    DEST_LINK = 2'd2,
    DEST_NONE = 2'd3
  } dest_sel_e;

  // Deepest load-use distance the scoreboard is designed for
  localparam int LOAD_LAT_MAX = 4;

  // Widest controller word supported; the bubble word is sliced to CTRL_W
  localparam int CTRL_W_MAX = 64;
  localparam logic [CTRL_W_MAX-1:0] CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/reg_file_bypass.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_bypass
// Purpose  : 2-read / 1-write register file with register 0 hardwired to
//            zero and write-first bypass on both read ports.
// Ports    : clk, rst_n      - clock, async active-low reset (clears file)
//            i_we/i_waddr/i_wdata - write port
//            i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b - combinational reads
// Revision : 1.0  initial release
// ============================================================================
module reg_file_bypass #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int c_depth = 2 ** REG_AW;

  logic [DATA_W-1:0] r_regs [c_depth];
  logic              w_wr_en;

  // Writes to register 0 are discarded so it never leaves zero
  assign w_wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle writeback is returned directly (write-first)
  always_comb begin
    if (i_raddr_a == '0)                        o_rdata_a = '0;
    else if (w_wr_en && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
    else                                        o_rdata_a = r_regs[i_raddr_a];
  end

  always_comb begin
    if (i_raddr_b == '0)                        o_rdata_b = '0;
    else if (w_wr_en && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
    else                                        o_rdata_b = r_regs[i_raddr_b];
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_stage
// Purpose  : Decode stage ending in the ID/EX pipeline register. Reads the
//            register file (with writeback bypass), extends imm16, selects
//            the destination, detects load-use hazards and inserts bubbles.
// Ports    : Clock/Reset_n            - clock, async active-low reset
//            IF_Valid/Instruction     - IF/ID contents
//            Ctrl_*                   - external controller decode
//            WB_RegWrite/Dest/Data    - writeback port
//            Flush, EX_Stall          - pipeline control from downstream
//            ID_Stall                 - freeze PC and IF/ID
//            EX_*                     - ID/EX register outputs
//            Perf_StallCycles/Bubbles - performance counters
// Config   : `define ID_PERF_CNT_EN to build the performance counters;
//            otherwise both Perf_* outputs are constant 0.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe_stage
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int CTRL_W   = 16,
  parameter int LOAD_LAT = 1,   // 1..LOAD_LAT_MAX
  parameter int LINK_REG = 31
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              IF_Valid,
  input  logic [31:0]       Instruction,
  input  logic [CTRL_W-1:0] Ctrl_In,
  input  logic              Ctrl_IsLoad,
  input  logic              Ctrl_UsesRs,
  input  logic              Ctrl_UsesRt,
  input  logic [1:0]        Ctrl_DestSel,
  input  logic              Ctrl_ExtZero,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Dest,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              Flush,
  input  logic              EX_Stall,
  output logic              ID_Stall,
  output logic              EX_Valid,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic              EX_IsLoad,
  output logic [DATA_W-1:0] EX_Rs_Data,
  output logic [DATA_W-1:0] EX_Rt_Data,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [REG_AW-1:0] EX_Rs,
  output logic [REG_AW-1:0] EX_Rt,
  output logic [REG_AW-1:0] EX_Dest,
  output logic [31:0]       Perf_StallCycles,
  output logic [31:0]       Perf_Bubbles
);

  // ---------------- field decode ----------------
  logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dest;
  logic [15:0]       w_imm16;
  logic [DATA_W-1:0] w_imm, w_rs_data, w_rt_data;
  logic              w_unused_opcode;

  assign w_rs            = REG_AW'(Instruction[25:21]);
  assign w_rt            = REG_AW'(Instruction[20:16]);
  assign w_rd            = REG_AW'(Instruction[15:11]);
  assign w_imm16         = Instruction[15:0];
  assign w_unused_opcode = ^Instruction[31:26];

  assign w_imm = Ctrl_ExtZero ? {{(DATA_W-16){1'b0}}, w_imm16}
                              : {{(DATA_W-16){w_imm16[15]}}, w_imm16};

  always_comb begin
    w_dest = '0;
    case (dest_sel_e'(Ctrl_DestSel))
      DEST_RT:   w_dest = w_rt;
      DEST_RD:   w_dest = w_rd;
      DEST_LINK: w_dest = REG_AW'(LINK_REG);
      default:   w_dest = '0;
    endcase
  end

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .i_we      (WB_RegWrite),
    .i_waddr   (WB_Dest),
    .i_wdata   (WB_Data),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rt_data)
  );

  // ---------------- load scoreboard ----------------
  // Entry 0 is the ID/EX register itself; older entries are flops that age
  // one step per cycle in which execute accepts.
  logic [LOAD_LAT-1:0] w_sb_valid;
  logic [REG_AW-1:0]   w_sb_dest [LOAD_LAT];

  assign w_sb_valid[0] = EX_Valid & EX_IsLoad;
  assign w_sb_dest[0]  = EX_Dest;

  for (genvar gi = 1; gi < LOAD_LAT; gi++) begin : g_sb
    logic              r_valid;
    logic [REG_AW-1:0] r_dest;
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        r_valid <= 1'b0;
        r_dest  <= '0;
      end else if (!EX_Stall) begin
        r_valid <= w_sb_valid[gi-1];
        r_dest  <= w_sb_dest[gi-1];
      end
    end
    assign w_sb_valid[gi] = r_valid;
    assign w_sb_dest[gi]  = r_dest;
  end

  // Loads into $0 never create a dependency
  logic w_hazard;
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (IF_Valid && w_sb_valid[i] && (w_sb_dest[i] != '0) &&
          ((Ctrl_UsesRs && (w_rs == w_sb_dest[i])) ||
           (Ctrl_UsesRt && (w_rt == w_sb_dest[i]))))
        w_hazard = 1'b1;
    end
  end

  assign ID_Stall = w_hazard | EX_Stall;

  // ---------------- ID/EX register ----------------
  // Bubbles clear only the fields that give the slot meaning; operand,
  // immediate and index fields are left as don't-care.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      EX_Valid   <= 1'b0;
      EX_Ctrl    <= '0;
      EX_IsLoad  <= 1'b0;
      EX_Rs_Data <= '0;
      EX_Rt_Data <= '0;
      EX_Imm     <= '0;
      EX_Rs      <= '0;
      EX_Rt      <= '0;
      EX_Dest    <= '0;
    end else if (Flush) begin
      EX_Valid  <= 1'b0;
      EX_Ctrl   <= CTRL_BUBBLE[CTRL_W-1:0];
      EX_IsLoad <= 1'b0;
      EX_Dest   <= '0;
    end else if (EX_Stall) begin
      // hold everything
    end else if (w_hazard || !IF_Valid) begin
      EX_Valid  <= 1'b0;
      EX_Ctrl   <= CTRL_BUBBLE[CTRL_W-1:0];
      EX_IsLoad <= 1'b0;
      EX_Dest   <= '0;
    end else begin
      EX_Valid   <= 1'b1;
      EX_Ctrl    <= Ctrl_In;
      EX_IsLoad  <= Ctrl_IsLoad;
      EX_Rs_Data <= w_rs_data;
      EX_Rt_Data <= w_rt_data;
      EX_Imm     <= w_imm;
      EX_Rs      <= w_rs;
      EX_Rt      <= w_rt;
      EX_Dest    <= w_dest;
    end
  end

  // ---------------- performance counters ----------------
`ifdef ID_PERF_CNT_EN
  logic        w_hazard_bubble;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_bubbles;

  // A hazard only produces a bubble when neither flush nor stall win
  assign w_hazard_bubble = w_hazard & ~Flush & ~EX_Stall;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_perf_stall   <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (ID_Stall)        r_perf_stall   <= r_perf_stall + 32'd1;
      if (w_hazard_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign Perf_StallCycles = r_perf_stall;
  assign Perf_Bubbles     = r_perf_bubbles;
`else
  assign Perf_StallCycles = '0;
  assign Perf_Bubbles     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_stage
// Purpose  : Directed self-checking bench. Two instances share stimulus:
//            dut_a with LOAD_LAT=1 and dut_b with LOAD_LAT=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_pipe_stage;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] instr;
  logic [15:0] ctrl_in;
  logic        is_load, uses_rs, uses_rt, ext_zero;
  logic [1:0]  dest_sel;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        flush, ex_stall;

  logic        a_id_stall, a_valid, a_isload;
  logic [15:0] a_ctrl;
  logic [31:0] a_rs_d, a_rt_d, a_imm, a_pstall, a_pbub;
  logic [4:0]  a_rs, a_rt, a_dest;

  logic        b_id_stall, b_valid, b_isload;
  logic [15:0] b_ctrl;
  logic [31:0] b_rs_d, b_rt_d, b_imm, b_pstall, b_pbub;
  logic [4:0]  b_rs, b_rt, b_dest;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.LOAD_LAT(1)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .IF_Valid(if_valid), .Instruction(instr),
    .Ctrl_In(ctrl_in), .Ctrl_IsLoad(is_load), .Ctrl_UsesRs(uses_rs),
    .Ctrl_UsesRt(uses_rt), .Ctrl_DestSel(dest_sel), .Ctrl_ExtZero(ext_zero),
    .WB_RegWrite(wb_we), .WB_Dest(wb_dest), .WB_Data(wb_data),
    .Flush(flush), .EX_Stall(ex_stall), .ID_Stall(a_id_stall),
    .EX_Valid(a_valid), .EX_Ctrl(a_ctrl), .EX_IsLoad(a_isload),
    .EX_Rs_Data(a_rs_d), .EX_Rt_Data(a_rt_d), .EX_Imm(a_imm),
    .EX_Rs(a_rs), .EX_Rt(a_rt), .EX_Dest(a_dest),
    .Perf_StallCycles(a_pstall), .Perf_Bubbles(a_pbub)
  );

  id_ex_pipe_stage #(.LOAD_LAT(3)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .IF_Valid(if_valid), .Instruction(instr),
    .Ctrl_In(ctrl_in), .Ctrl_IsLoad(is_load), .Ctrl_UsesRs(uses_rs),
    .Ctrl_UsesRt(uses_rt), .Ctrl_DestSel(dest_sel), .Ctrl_ExtZero(ext_zero),
    .WB_RegWrite(wb_we), .WB_Dest(wb_dest), .WB_Data(wb_data),
    .Flush(flush), .EX_Stall(ex_stall), .ID_Stall(b_id_stall),
    .EX_Valid(b_valid), .EX_Ctrl(b_ctrl), .EX_IsLoad(b_isload),
    .EX_Rs_Data(b_rs_d), .EX_Rt_Data(b_rt_d), .EX_Imm(b_imm),
    .EX_Rs(b_rs), .EX_Rt(b_rt), .EX_Dest(b_dest),
    .Perf_StallCycles(b_pstall), .Perf_Bubbles(b_pbub)
  );

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] i, input logic ld, input logic urs,
                           input logic urt, input logic [1:0] ds, input logic ez,
                           input logic [15:0] c);
    instr = i; is_load = ld; uses_rs = urs; uses_rt = urt;
    dest_sel = ds; ext_zero = ez; ctrl_in = c; if_valid = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", a_valid); else n_pass++;
    n_checks++; if ({a_ctrl, a_imm, a_dest, a_rs_d} !== '0) $display("FAIL reset_fields got=%h exp=0", {a_ctrl, a_imm, a_dest, a_rs_d}); else n_pass++;
    n_checks++; if (b_id_stall !== 1'b0) $display("FAIL reset_id_stall got=%b exp=0", b_id_stall); else n_pass++;
    ex_stall = 1'b1; #1;
    n_checks++; if (b_id_stall !== 1'b1) $display("FAIL reset_id_stall_exstall got=%b exp=1", b_id_stall); else n_pass++;
    ex_stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_addi();
    set_instr(32'h2008_0005, 1'b0, 1'b1, 1'b0, DEST_RT, 1'b0, 16'h00A5);
    tick();
    n_checks++; if (a_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", a_valid); else n_pass++;
    n_checks++; if (a_imm !== 32'd5) $display("FAIL addi_imm got=%h exp=5", a_imm); else n_pass++;
    n_checks++; if (a_dest !== 5'd8) $display("FAIL addi_dest got=%0d exp=8", a_dest); else n_pass++;
    n_checks++; if (a_ctrl !== 16'h00A5) $display("FAIL addi_ctrl got=%h exp=00a5", a_ctrl); else n_pass++;
    n_checks++; if (a_rt !== 5'd8) $display("FAIL addi_rt got=%0d exp=8", a_rt); else n_pass++;
    if_valid = 1'b0;
    tick();
    n_checks++; if (a_valid !== 1'b0) $display("FAIL idle_bubble got=%b exp=0", a_valid); else n_pass++;
  endtask

  task automatic test_load_use();
    set_instr(32'h8C08_0000, 1'b1, 1'b1, 1'b0, DEST_RT, 1'b0, 16'h0001); // lw $8,0($0)
    tick();
    n_checks++; if (a_isload !== 1'b1) $display("FAIL lw_isload got=%b exp=1", a_isload); else n_pass++;
    set_instr(32'h0108_4820, 1'b0, 1'b1, 1'b1, DEST_RD, 1'b0, 16'h0002); // add $9,$8,$8
    #1;
    n_checks++; if (a_id_stall !== 1'b1) $display("FAIL lu_a_stall0 got=%b exp=1", a_id_stall); else n_pass++;
    n_checks++; if (b_id_stall !== 1'b1) $display("FAIL lu_b_stall0 got=%b exp=1", b_id_stall); else n_pass++;
    tick();
    n_checks++; if (a_valid !== 1'b0) $display("FAIL lu_a_bubble got=%b exp=0", a_valid); else n_pass++;
    n_checks++; if (a_id_stall !== 1'b0) $display("FAIL lu_a_stall1 got=%b exp=0", a_id_stall); else n_pass++;
    n_checks++; if (b_valid !== 1'b0) $display("FAIL lu_b_bubble1 got=%b exp=0", b_valid); else n_pass++;
    n_checks++; if (b_id_stall !== 1'b1) $display("FAIL lu_b_stall1 got=%b exp=1", b_id_stall); else n_pass++;
    tick();
    n_checks++; if ({a_valid, a_dest} !== {1'b1, 5'd9}) $display("FAIL lu_a_add got=%b/%0d exp=1/9", a_valid, a_dest); else n_pass++;
    n_checks++; if (b_valid !== 1'b0) $display("FAIL lu_b_bubble2 got=%b exp=0", b_valid); else n_pass++;
    n_checks++; if (b_id_stall !== 1'b1) $display("FAIL lu_b_stall2 got=%b exp=1", b_id_stall); else n_pass++;
    tick();
    n_checks++; if (b_valid !== 1'b0) $display("FAIL lu_b_bubble3 got=%b exp=0", b_valid); else n_pass++;
    n_checks++; if (b_id_stall !== 1'b0) $display("FAIL lu_b_stall3 got=%b exp=0", b_id_stall); else n_pass++;
    tick();
    n_checks++; if ({b_valid, b_dest} !== {1'b1, 5'd9}) $display("FAIL lu_b_add got=%b/%0d exp=1/9", b_valid, b_dest); else n_pass++;
    if_valid = 1'b0;
  endtask

  task automatic test_perf();
    logic [31:0] exp_a_bub, exp_b_bub, exp_b_stall;
`ifdef ID_PERF_CNT_EN
    exp_a_bub = 32'd1; exp_b_bub = 32'd3; exp_b_stall = 32'd3;
`else
    exp_a_bub = 32'd0; exp_b_bub = 32'd0; exp_b_stall = 32'd0;
`endif
    n_checks++; if (a_pbub !== exp_a_bub) $display("FAIL perf_a_bubbles got=%0d exp=%0d", a_pbub, exp_a_bub); else n_pass++;
    n_checks++; if (b_pbub !== exp_b_bub) $display("FAIL perf_b_bubbles got=%0d exp=%0d", b_pbub, exp_b_bub); else n_pass++;
    n_checks++; if (b_pstall !== exp_b_stall) $display("FAIL perf_b_stalls got=%0d exp=%0d", b_pstall, exp_b_stall); else n_pass++;
  endtask

  task automatic test_load_zero();
    tick();
    set_instr(32'h8C00_0000, 1'b1, 1'b1, 1'b0, DEST_RT, 1'b0, 16'h0001); // lw $0
    tick();
    set_instr(32'h0000_4820, 1'b0, 1'b1, 1'b1, DEST_RD, 1'b0, 16'h0002); // add $9,$0,$0
    #1;
    n_checks++; if (b_id_stall !== 1'b0) $display("FAIL lz_b_stall got=%b exp=0", b_id_stall); else n_pass++;
    n_checks++; if (a_id_stall !== 1'b0) $display("FAIL lz_a_stall got=%b exp=0", a_id_stall); else n_pass++;
    tick();
    n_checks++; if ({b_valid, b_dest} !== {1'b1, 5'd9}) $display("FAIL lz_b_add got=%b/%0d exp=1/9", b_valid, b_dest); else n_pass++;
    n_checks++; if (b_id_stall !== 1'b0) $display("FAIL lz_b_stall1 got=%b exp=0", b_id_stall); else n_pass++;
    if_valid = 1'b0;
  endtask

  task automatic test_bypass();
    set_instr(32'h0120_5020, 1'b0, 1'b1, 1'b1, DEST_RD, 1'b0, 16'h0003); // add $10,$9,$0
    wb_we = 1'b1; wb_dest = 5'd9; wb_data = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (b_rs_d !== 32'hDEAD_BEEF) $display("FAIL bypass_rs got=%h exp=deadbeef", b_rs_d); else n_pass++;
    n_checks++; if (a_rs_d !== 32'hDEAD_BEEF) $display("FAIL bypass_rs_a got=%h exp=deadbeef", a_rs_d); else n_pass++;
    wb_we = 1'b0;
    set_instr(32'h0009_5020, 1'b0, 1'b1, 1'b1, DEST_RD, 1'b0, 16'h0003); // add $10,$0,$9
    tick();
    n_checks++; if (b_rt_d !== 32'hDEAD_BEEF) $display("FAIL rf_rt got=%h exp=deadbeef", b_rt_d); else n_pass++;
    wb_we = 1'b1; wb_dest = 5'd0; wb_data = 32'h1234_5678;
    set_instr(32'h0000_5020, 1'b0, 1'b1, 1'b1, DEST_RD, 1'b0, 16'h0003); // add $10,$0,$0
    tick();
    n_checks++; if ({b_rs_d, b_rt_d} !== 64'd0) $display("FAIL r0_bypass got=%h exp=0", {b_rs_d, b_rt_d}); else n_pass++;
    wb_we = 1'b0;
    tick();
    n_checks++; if (b_rs_d !== 32'd0) $display("FAIL r0_write got=%h exp=0", b_rs_d); else n_pass++;
    if_valid = 1'b0;
  endtask

  task automatic test_stall_flush();
    set_instr(32'h2008_0005, 1'b0, 1'b1, 1'b0, DEST_RT, 1'b0, 16'h1234);
    tick();
    n_checks++; if ({b_valid, b_ctrl} !== {1'b1, 16'h1234}) $display("FAIL sf_capture got=%b/%h exp=1/1234", b_valid, b_ctrl); else n_pass++;
    set_instr(32'h200A_0007, 1'b0, 1'b1, 1'b0, DEST_RT, 1'b0, 16'h4321);
    ex_stall = 1'b1;
    #1;
    n_checks++; if (b_id_stall !== 1'b1) $display("FAIL sf_id_stall got=%b exp=1", b_id_stall); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({b_valid, b_ctrl, b_imm, b_dest} !== {1'b1, 16'h1234, 32'd5, 5'd8})
        $display("FAIL sf_hold%0d got=%b/%h/%h/%0d exp=1/1234/5/8", k, b_valid, b_ctrl, b_imm, b_dest);
      else n_pass++;
      n_checks++; if (b_id_stall !== 1'b1) $display("FAIL sf_id_stall%0d got=%b exp=1", k, b_id_stall); else n_pass++;
    end
    flush = 1'b1;
    tick();
    n_checks++; if ({b_valid, b_ctrl, b_dest} !== '0) $display("FAIL sf_flush got=%b/%h/%0d exp=0/0/0", b_valid, b_ctrl, b_dest); else n_pass++;
    flush = 1'b0; ex_stall = 1'b0;
    tick();
    n_checks++; if ({b_valid, b_imm, b_dest} !== {1'b1, 32'd7, 5'd10}) $display("FAIL sf_resume got=%b/%h/%0d exp=1/7/10", b_valid, b_imm, b_dest); else n_pass++;
    if_valid = 1'b0;
  endtask

  task automatic test_imm_dest();
    set_instr(32'h2008_8000, 1'b0, 1'b1, 1'b0, DEST_LINK, 1'b0, 16'h0005);
    tick();
    n_checks++; if (b_imm !== 32'hFFFF_8000) $display("FAIL imm_sext got=%h exp=ffff8000", b_imm); else n_pass++;
    n_checks++; if (b_dest !== 5'd31) $display("FAIL dest_link got=%0d exp=31", b_dest); else n_pass++;
    set_instr(32'h2008_8000, 1'b0, 1'b1, 1'b0, DEST_NONE, 1'b1, 16'h0005);
    tick();
    n_checks++; if (b_imm !== 32'h0000_8000) $display("FAIL imm_zext got=%h exp=00008000", b_imm); else n_pass++;
    n_checks++; if (b_dest !== 5'd0) $display("FAIL dest_none got=%0d exp=0", b_dest); else n_pass++;
    if_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_instr(32'h8C08_0000, 1'b1, 1'b1, 1'b0, DEST_RT, 1'b0, 16'h0001); // lw $8
    tick();
    set_instr(32'h0120_5020, 1'b0, 1'b1, 1'b1, DEST_RD, 1'b0, 16'h0003); // add $10,$9,$0 reads $9
    instr[20:16] = 5'd8; // also consume $8 on rt
    #1;
    n_checks++; if (b_id_stall !== 1'b1) $display("FAIL rms_hazard got=%b exp=1", b_id_stall); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (b_id_stall !== 1'b0) $display("FAIL rms_cleared got=%b exp=0", b_id_stall); else n_pass++;
    n_checks++; if (b_valid !== 1'b0) $display("FAIL rms_valid got=%b exp=0", b_valid); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_checks++; if ({b_valid, b_rs_d} !== {1'b1, 32'd0}) $display("FAIL rms_rf_clear got=%b/%h exp=1/0", b_valid, b_rs_d); else n_pass++;
    if_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; instr = '0; ctrl_in = '0;
    is_load = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; ext_zero = 1'b0;
    dest_sel = DEST_NONE; wb_we = 1'b0; wb_dest = '0; wb_data = '0;
    flush = 1'b0; ex_stall = 1'b0;

    test_reset();
    test_addi();
    test_load_use();
    test_perf();
    test_load_zero();
    test_bypass();
    test_stall_flush();
    test_imm_dest();
    test_reset_mid_stall();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
